// File: rtl/axis_reg_pcie_txs.sv
// ---------------------------------------------------------------------------
// axis_reg_pcie_txs
//
// Multi-stage AXI-Stream pipeline register for the PCIe TX streaming path.
// It sits between the AFU/mux TX master and the PCIe IP TX sink and breaks
// timing on tdata/tuser/tlast/tvalid and tready. Each stage holds its own
// buffer. The module also reports how many beats all stages hold in total.
//
// Parameters
//   NUM_PIPELINES   number of cascaded stages (>= 1).
//   MODE            0: skid buffer (registered tready, up to 2 beats/stage)
//                   1: simple buffer (combinational tready, 1 beat/stage)
//                   2: bypass (wires only, no state)
//   TREADY_RST_VAL  MODE 0 only: s_if_tready value while s_if_rst is high.
//   TDATA_W/TUSER_W flattened widths of the t_axis_pcie_txs tdata/tuser.
//
// Ports
//   s_if_clk, s_if_rst    clock and synchronous active-high reset.
//   s_if_t*               sink side beat from the upstream TX master.
//   s_if_tready           ready to the upstream TX master.
//   m_if_clk, m_if_rst    forwarded copies of s_if_clk / s_if_rst.
//   m_if_t*               source side beat to the PCIe TX sink.
//   m_if_tready           ready from the PCIe TX sink.
//   occupancy             beats currently held in all stages (0 in bypass).
// ---------------------------------------------------------------------------
module axis_reg_pcie_txs #(
    parameter int NUM_PIPELINES  = 1,
    parameter int MODE           = 0,
    parameter bit TREADY_RST_VAL = 1'b0,
    parameter int TDATA_W        = 512,
    parameter int TUSER_W        = 20,
    parameter int OCC_W          = $clog2(2 * ((NUM_PIPELINES < 1) ? 1 : NUM_PIPELINES) + 1)
) (
    input  logic               s_if_clk,
    input  logic               s_if_rst,
    input  logic               s_if_tvalid,
    input  logic               s_if_tlast,
    input  logic [TDATA_W-1:0] s_if_tdata,
    input  logic [TUSER_W-1:0] s_if_tuser,
    output logic               s_if_tready,
    output logic               m_if_clk,
    output logic               m_if_rst,
    output logic               m_if_tvalid,
    output logic               m_if_tlast,
    output logic [TDATA_W-1:0] m_if_tdata,
    output logic [TUSER_W-1:0] m_if_tuser,
    input  logic               m_if_tready,
    output logic [OCC_W-1:0]   occupancy
);

    localparam int NP     = (NUM_PIPELINES < 1) ? 1 : NUM_PIPELINES;
    localparam int BEAT_W = 1 + TUSER_W + TDATA_W;

    assign m_if_clk = s_if_clk;
    assign m_if_rst = s_if_rst;

    if (NUM_PIPELINES < 1) begin : g_bad_param
        $error("axis_reg_pcie_txs: NUM_PIPELINES must be >= 1");
    end

    if (MODE == 2) begin : g_bypass
        assign m_if_tvalid = s_if_tvalid;
        assign m_if_tlast  = s_if_tlast;
        assign m_if_tdata  = s_if_tdata;
        assign m_if_tuser  = s_if_tuser;
        assign s_if_tready = m_if_tready;
        assign occupancy   = '0;
    end else begin : g_pipe
        // Link k is the sink of stage k; link NP is the module source port.
        logic [NP:0]             w_valid;
        logic [NP:0]             w_ready;
        logic [NP:0][BEAT_W-1:0] w_beat;
        logic                    w_push;
        logic                    w_pop;
        logic [OCC_W-1:0]        r_occ;

        assign w_valid[0]  = s_if_tvalid;
        assign w_beat[0]   = {s_if_tlast, s_if_tuser, s_if_tdata};
        assign s_if_tready = w_ready[0];

        assign m_if_tvalid = w_valid[NP];
        assign {m_if_tlast, m_if_tuser, m_if_tdata} = w_beat[NP];
        assign w_ready[NP] = m_if_tready;

        for (genvar k = 0; k < NP; k++) begin : g_stage
            if (MODE == 0) begin : g_skid
                logic              r_main_valid;
                logic              r_skid_valid;
                logic              r_ready;
                logic [BEAT_W-1:0] r_main_beat;
                logic [BEAT_W-1:0] r_skid_beat;
                logic              w_main_valid_nxt;
                logic              w_skid_valid_nxt;
                logic              w_load_main_in;
                logic              w_load_main_skid;
                logic              w_load_skid_in;

                // r_ready is only ever high while the skid slot is empty.
                always_comb begin
                    // NOTE: every always_comb output gets a default first so no latch is inferred.
                    w_main_valid_nxt = r_main_valid;
                    w_skid_valid_nxt = r_skid_valid;
                    w_load_main_in   = 1'b0;
                    w_load_main_skid = 1'b0;
                    w_load_skid_in   = 1'b0;
                    if (r_ready) begin
                        if (w_ready[k+1] || !r_main_valid) begin
                            // Main is free or popping this cycle: no bubble.
                            w_main_valid_nxt = w_valid[k];
                            w_load_main_in   = w_valid[k];
                        end else begin
                            // Main is stuck: catch the beat in the skid slot.
                            w_skid_valid_nxt = w_valid[k];
                            w_load_skid_in   = w_valid[k];
                        end
                    end else if (w_ready[k+1]) begin
                        w_main_valid_nxt = 1'b1;
                        w_skid_valid_nxt = 1'b0;
                        w_load_main_skid = 1'b1;
                    end
                end

                always_ff @(posedge s_if_clk) begin
                    // NOTE: sequential state uses non-blocking assignments only.
                    if (s_if_rst) begin
                        r_main_valid <= 1'b0;
                        r_skid_valid <= 1'b0;
                        r_ready      <= 1'b1;
                    end else begin
                        r_main_valid <= w_main_valid_nxt;
                        r_skid_valid <= w_skid_valid_nxt;
                        r_ready      <= ~w_skid_valid_nxt;
                    end
                end

                // NOTE: payload registers carry no reset; the valid flags alone qualify them.
                always_ff @(posedge s_if_clk) begin
                    if (w_load_main_in) begin
                        r_main_beat <= w_beat[k];
                    end else if (w_load_main_skid) begin
                        r_main_beat <= r_skid_beat;
                    end
                    if (w_load_skid_in) begin
                        r_skid_beat <= w_beat[k];
                    end
                end

                // While in reset the upstream sees the configured value.
                assign w_ready[k]   = s_if_rst ? TREADY_RST_VAL : r_ready;
                assign w_valid[k+1] = r_main_valid;
                assign w_beat[k+1]  = r_main_beat;
            end else begin : g_simple
                logic              r_main_valid;
                logic [BEAT_W-1:0] r_main_beat;

                assign w_ready[k] = ~r_main_valid | w_ready[k+1];

                always_ff @(posedge s_if_clk) begin
                    if (s_if_rst) begin
                        r_main_valid <= 1'b0;
                    end else if (w_ready[k]) begin
                        r_main_valid <= w_valid[k];
                    end
                end

                always_ff @(posedge s_if_clk) begin
                    if (w_ready[k] && w_valid[k]) begin
                        r_main_beat <= w_beat[k];
                    end
                end

                assign w_valid[k+1] = r_main_valid;
                assign w_beat[k+1]  = r_main_beat;
            end
        end

        assign w_push = s_if_tvalid & w_ready[0];
        assign w_pop  = w_valid[NP] & m_if_tready;

        always_ff @(posedge s_if_clk) begin
            if (s_if_rst) begin
                r_occ <= '0;
            end else if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end

        assign occupancy = r_occ;
    end

endmodule

// File: tb/tb_axis_reg_pcie_txs.sv
// ---------------------------------------------------------------------------
// tb_axis_reg_pcie_txs
//
// Four instances with NUM_PIPELINES=2: ch0 skid (TREADY_RST_VAL=0),
// ch1 skid (TREADY_RST_VAL=1), ch2 simple buffer, ch3 bypass. Directed
// steps cover reset, streaming latency, back-pressure capacity, mid-packet
// reset and bypass; a randomized phase checks ch0 and ch2 against a queue
// model (accepted beats leave in order; occupancy equals beats in flight).
// ---------------------------------------------------------------------------
module tb_axis_reg_pcie_txs;

    localparam int NP     = 2;
    localparam int DW     = 32;
    localparam int UW     = 8;
    localparam int BW     = 1 + UW + DW;
    localparam int OW     = $clog2(2 * NP + 1);
    localparam int NCH    = 4;
    localparam int N_RAND = 10000;
    localparam int MODES [NCH] = '{0, 0, 1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_valid [NCH];
    logic          s_last  [NCH];
    logic [DW-1:0] s_data  [NCH];
    logic [UW-1:0] s_user  [NCH];
    logic          s_ready [NCH];
    logic          m_valid [NCH];
    logic          m_last  [NCH];
    logic [DW-1:0] m_data  [NCH];
    logic [UW-1:0] m_user  [NCH];
    logic          m_ready [NCH];
    logic [OW-1:0] occ     [NCH];
    logic          m_clk   [NCH];
    logic          m_rst   [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_dut
        axis_reg_pcie_txs #(
            .NUM_PIPELINES (NP),
            .MODE          (MODES[g]),
            .TREADY_RST_VAL((g == 1) ? 1'b1 : 1'b0),
            .TDATA_W       (DW),
            .TUSER_W       (UW)
        ) u_dut (
            .s_if_clk    (clk),
            .s_if_rst    (rst),
            .s_if_tvalid (s_valid[g]),
            .s_if_tlast  (s_last[g]),
            .s_if_tdata  (s_data[g]),
            .s_if_tuser  (s_user[g]),
            .s_if_tready (s_ready[g]),
            .m_if_clk    (m_clk[g]),
            .m_if_rst    (m_rst[g]),
            .m_if_tvalid (m_valid[g]),
            .m_if_tlast  (m_last[g]),
            .m_if_tdata  (m_data[g]),
            .m_if_tuser  (m_user[g]),
            .m_if_tready (m_ready[g]),
            .occupancy   (occ[g])
        );
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string name, input int ch);
        return $sformatf("%s_ch%0d", name, ch);
    endfunction

    function automatic logic [BW-1:0] m_beat(input int ch);
        return {m_last[ch], m_user[ch], m_data[ch]};
    endfunction

    function automatic logic [BW-1:0] s_beat(input int ch);
        return {s_last[ch], s_user[ch], s_data[ch]};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int            cap       [NCH];
    int            n_acc     [NCH];
    int            n_in      [NCH];
    int            n_out     [NCH];
    logic [BW-1:0] sb_q      [NCH][$];
    logic          fire_in   [NCH];
    logic          stall_prev[NCH];
    logic [BW-1:0] beat_prev [NCH];

    initial begin
        cap = '{2 * NP, 2 * NP, NP, 0};
        for (int ch = 0; ch < NCH; ch++) begin
            s_valid[ch] = 1'b0;
            s_last[ch]  = 1'b0;
            s_data[ch]  = '0;
            s_user[ch]  = '0;
            m_ready[ch] = 1'b1;
        end

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_sready_trv0", 64'(s_ready[0]), 64'd0);
        check("rst_sready_trv1", 64'(s_ready[1]), 64'd1);
        check("rst_forward", 64'(m_rst[0]), 64'd1);
        for (int ch = 0; ch < 3; ch++) begin
            check(tg("rst_mvalid", ch), 64'(m_valid[ch]), 64'd0);
            check(tg("rst_occ", ch), 64'(occ[ch]), 64'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int ch = 0; ch < 3; ch++) begin
            check(tg("post_rst_sready", ch), 64'(s_ready[ch]), 64'd1);
            check(tg("post_rst_mvalid", ch), 64'(m_valid[ch]), 64'd0);
        end

        // ---------------- 8-beat stream, sink always ready ----------------
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int ch = 0; ch < 3; ch += 2) begin
                s_valid[ch] = (c < 8);
                s_data[ch]  = DW'(c);
                s_user[ch]  = UW'(c * 3);
                s_last[ch]  = (c == 7);
            end
            @(negedge clk);
            for (int ch = 0; ch < 3; ch += 2) begin
                automatic int   k_in  = (c < 8) ? c : 8;
                automatic int   k_out = (c < 2) ? 0 : ((c - 2 < 8) ? c - 2 : 8);
                automatic logic exp_v = (c >= 2) && (c < 10);
                check(tg("t1_sready", ch), 64'(s_ready[ch]), 64'd1);
                check(tg("t1_mvalid", ch), 64'(m_valid[ch]), 64'(exp_v));
                if (exp_v) begin
                    check(tg("t1_tdata", ch), 64'(m_data[ch]), 64'(c - 2));
                    check(tg("t1_tuser", ch), 64'(m_user[ch]), 64'(UW'((c - 2) * 3)));
                    check(tg("t1_tlast", ch), 64'(m_last[ch]), 64'(c - 2 == 7));
                end
                check(tg("t1_occ", ch), 64'(occ[ch]), 64'(k_in - k_out));
            end
        end

        // ---------------- back-pressure: sink stalled, 6 beats offered ----------------
        n_acc = '{0, 0, 0, 0};
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int ch = 0; ch < 3; ch += 2) begin
                m_ready[ch] = 1'b0;
                s_valid[ch] = (n_acc[ch] < 6);
                s_data[ch]  = DW'(32'h100 + n_acc[ch]);
                s_user[ch]  = '0;
                s_last[ch]  = (n_acc[ch] == 5);
            end
            @(negedge clk);
            for (int ch = 0; ch < 3; ch += 2) begin
                automatic logic exp_r = (n_acc[ch] < cap[ch]);
                check(tg("t2_sready", ch), 64'(s_ready[ch]), 64'(exp_r));
                check(tg("t2_mvalid", ch), 64'(m_valid[ch]), 64'(c >= 2));
                if (c >= 2) check(tg("t2_tdata_hold", ch), 64'(m_data[ch]), 64'h100);
                check(tg("t2_occ", ch), 64'(occ[ch]), 64'(n_acc[ch]));
                if (exp_r) n_acc[ch]++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            tick();
            for (int ch = 0; ch < 3; ch += 2) begin
                s_valid[ch] = 1'b0;
                m_ready[ch] = 1'b1;
            end
            @(negedge clk);
            for (int ch = 0; ch < 3; ch += 2) begin
                automatic logic exp_v = (j < cap[ch]);
                check(tg("t2_drain_mvalid", ch), 64'(m_valid[ch]), 64'(exp_v));
                if (exp_v) check(tg("t2_drain_tdata", ch), 64'(m_data[ch]), 64'(32'h100 + j));
                check(tg("t2_drain_occ", ch), 64'(occ[ch]), 64'(exp_v ? cap[ch] - j : 0));
            end
        end

        // ---------------- reset with 3 beats held mid-packet ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            m_ready[0] = 1'b0;
            s_valid[0] = 1'b1;
            s_data[0]  = DW'(32'h200 + i);
            s_last[0]  = 1'b0;
            @(negedge clk);
            check("t6_fill_sready", 64'(s_ready[0]), 64'd1);
        end
        tick();
        rst        = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = DW'(32'h77);
        s_last[0]  = 1'b1;
        @(negedge clk);
        check("t6_pre_rst_occ", 64'(occ[0]), 64'd3);
        check("t6_pre_rst_mvalid", 64'(m_valid[0]), 64'd1);
        tick();
        rst        = 1'b0;
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        @(negedge clk);
        check("t6_flush_mvalid", 64'(m_valid[0]), 64'd0);
        check("t6_flush_occ", 64'(occ[0]), 64'd0);
        check("t6_flush_sready", 64'(s_ready[0]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            s_valid[0] = (c == 0);
            s_data[0]  = DW'(32'hA5);
            s_last[0]  = 1'b1;
            @(negedge clk);
            check("t6_new_mvalid", 64'(m_valid[0]), 64'(c == 2));
            if (c == 2) begin
                check("t6_new_tdata", 64'(m_data[0]), 64'hA5);
                check("t6_new_tlast", 64'(m_last[0]), 64'd1);
            end
            check("t6_new_occ", 64'(occ[0]), 64'((c == 1 || c == 2) ? 1 : 0));
        end

        // ---------------- bypass: same-cycle pass-through ----------------
        for (int i = 0; i < 16; i++) begin
            tick();
            s_valid[3] = 1'($urandom_range(1));
            s_last[3]  = 1'($urandom_range(1));
            s_data[3]  = DW'($urandom);
            s_user[3]  = UW'($urandom);
            m_ready[3] = 1'($urandom_range(1));
            @(negedge clk);
            check("byp_beat", 64'({m_valid[3], m_beat(3)}), 64'({s_valid[3], s_beat(3)}));
            check("byp_sready", 64'(s_ready[3]), 64'(m_ready[3]));
            check("byp_occ", 64'(occ[3]), 64'd0);
        end

        // ---------------- randomized traffic against a queue model ----------------
        for (int ch = 0; ch < NCH; ch++) begin
            n_in[ch]       = 0;
            n_out[ch]      = 0;
            fire_in[ch]    = 1'b0;
            stall_prev[ch] = 1'b0;
            beat_prev[ch]  = '0;
            sb_q[ch].delete();
        end
        for (int cyc = 0; cyc < 80000 && (n_out[0] < N_RAND || n_out[2] < N_RAND); cyc++) begin
            tick();
            for (int ch = 0; ch < 3; ch += 2) begin
                if (!s_valid[ch] || fire_in[ch]) begin
                    if (n_in[ch] < N_RAND && $urandom_range(99) < 70) begin
                        s_valid[ch] = 1'b1;
                        s_data[ch]  = DW'($urandom);
                        s_user[ch]  = UW'($urandom);
                        s_last[ch]  = ($urandom_range(3) == 0);
                        n_in[ch]++;
                    end else begin
                        s_valid[ch] = 1'b0;
                    end
                end
                m_ready[ch] = 1'($urandom_range(1));
            end
            @(negedge clk);
            for (int ch = 0; ch < 3; ch += 2) begin
                check(tg("rnd_occ", ch), 64'(occ[ch]), 64'(sb_q[ch].size()));
                if (stall_prev[ch]) begin
                    check(tg("rnd_stall_hold", ch), 64'({m_valid[ch], m_beat(ch)}),
                          64'({1'b1, beat_prev[ch]}));
                end
                if (m_valid[ch] && m_ready[ch]) begin
                    if (sb_q[ch].size() == 0) begin
                        check(tg("rnd_unexpected_beat", ch), 64'(m_valid[ch]), 64'd0);
                    end else begin
                        check(tg("rnd_beat", ch), 64'(m_beat(ch)), 64'(sb_q[ch].pop_front()));
                        n_out[ch]++;
                    end
                end
                fire_in[ch] = s_valid[ch] && s_ready[ch];
                if (fire_in[ch]) sb_q[ch].push_back(s_beat(ch));
                stall_prev[ch] = m_valid[ch] && !m_ready[ch];
                beat_prev[ch]  = m_beat(ch);
            end
        end
        for (int ch = 0; ch < 3; ch += 2) begin
            check(tg("rnd_delivered", ch), 64'(n_out[ch]), 64'(N_RAND));
            check(tg("rnd_leftover", ch), 64'(sb_q[ch].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
